cldiv: RTL
==========

Name: cldiv

Overview:
- Multi-cycle carry-less (GF(2) polynomial) divider. It is the inverse operation of the pipeline's two-cycle carry-less multiplier.
- Computes quotient and remainder of a 64-bit dividend polynomial by a 32-bit divisor polynomial.
- Used for the clmul-reduction/CRC/GF-reduction path. Shares the multiplier's start/stall/eoc control style so the execute stage drives both the same way.
- Processes IT_PER_CYCLE dividend bits per cycle, MSB first.

Parameters:
- IT_PER_CYCLE, 8, dividend bits consumed per non-stalled cycle. Legal values: 1, 2, 4, 8, 16, 32, 64 (must divide 64).
- STEPS, 64/IT_PER_CYCLE, derived localparam: number of compute cycles.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  launch a new division. Sampled only when stall=0.
- stall  in  1  pipeline stall. Freezes all state.
- eoc  out  1  end of computation. Combinational: (state==0) && !start.
- N  in  64  dividend polynomial. Sampled with start.
- D  in  32  divisor polynomial. Sampled with start.
- quo  out  64  quotient, registered.
- rem  out  32  remainder, registered; degree < deg(D).
- div0  out  1  divisor was zero, registered.

Behaviour:
- Reset (resetn=0 at a clk edge): state=0, quo=0, rem=0, div0=0, internal dividend/degree registers=0. eoc=1 while start=0.
- stall=1: no register changes. start is ignored. Outputs hold.
- start=1 and stall=0 at an edge:
  - capture N into shift register nsh.
  - capture D.
  - deg = index of the MSB set in D (priority encode), registered.
  - rem=0, quo=0, div0=(D==0), state=STEPS.
  - start overrides any in-flight operation (abort and restart). No partial result is required.
- Compute edge (stall=0, start=0, state!=0): perform IT_PER_CYCLE iterations in sequence, then state=state-1. One iteration:
  - b = nsh[63]; nsh = nsh<<1.
  - r = {rem[30:0], b}.
  - qb = r[deg]; if qb then r = r ^ D; rem = r.
  - quo = {quo[62:0], qb}.
  - Width rule: rem holds degree <= deg-1 before the shift, so degree <= deg after it. 32 bits always suffice.
- Idle edge (stall=0, start=0, state==0): no change. Results stay stable indefinitely.
- div0 case (D==0): iterations are suppressed. At completion quo=0 and rem=N[31:0], div0=1. Latency is identical to the normal case.
- D==1 (deg=0): quo=N, rem=0.
- Latency:
  - Start accepted at edge k; results valid and eoc=1 after edge k+STEPS (8 edges at default), counting only non-stalled edges.
  - eoc=0 for the whole busy window, and in any cycle where start=1.
- Correctness invariant: clmul(quo, D) XOR rem == N (zero-extended). deg(rem) < deg(D) for D!=0.
- Back-to-back: start may be asserted in the same cycle eoc would otherwise be 1. The old results are overwritten at that edge.

Test Plan:
- N=0x5, D=0x3, start 1 cycle, no stall -> eoc rises 8 cycles later; quo=0x3, rem=0x0, div0=0.
- N=0x2B79, D=0x11B (AES poly) -> rem=0xC1; clmul(quo,0x11B)^rem==0x2B79.
- N=0x0000_0001_2345_6789, D=0x8000_0000 -> quo=0x2, rem=0x2345_6789. Also N=all-ones, D=0x1 -> quo=0xFFFF_FFFF_FFFF_FFFF, rem=0.
- N=0x1234, D=0 -> after 8 cycles div0=1, quo=0, rem=0x1234. Next start with D=0x3 clears div0.
- N=0x7, D=0x3 with stall held 3 cycles mid-operation -> eoc after 8+3 cycles; quo=0x2, rem=0x1. Outputs and eoc frozen during stall. start asserted under stall is ignored.
- Restart mid-operation: start N=0x5/D=0x3, then at cycle 4 start N=0x7/D=0x3 -> eoc 8 cycles after the second start; quo=0x2, rem=0x1. Also assert resetn=0 mid-operation -> all outputs 0, eoc=1 the next cycle.

Source files
------------

// File: rtl/cldiv.sv
// Multi-cycle carry-less (GF(2)) divider: 64-bit dividend by 32-bit divisor,
// IT_PER_CYCLE dividend bits per cycle MSB first, with start/stall/eoc control.
module cldiv #(
  parameter int IT_PER_CYCLE = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        stall,
  output logic        eoc,
  input  logic [63:0] N,
  input  logic [31:0] D,
  output logic [63:0] quo,
  output logic [31:0] rem,
  output logic        div0,
  output logic [6:0]  o_dbg_state
);

  localparam int STEPS = 64 / IT_PER_CYCLE;
  localparam int SW    = $clog2(STEPS + 1);

  // Handshake: start is taken at a clk edge only when stall=0; eoc=1 means
  // idle with stable results and no start pending; stall freezes everything.

  logic [SW-1:0] r_state;
  logic [63:0]   r_nsh;
  logic [31:0]   r_d;
  logic [4:0]    r_deg;
  logic [63:0]   r_quo;
  logic [31:0]   r_rem;
  logic          r_div0;

  logic [4:0]    w_deg;
  logic [63:0]   w_nsh;
  logic [63:0]   w_quo;
  logic [31:0]   w_rem;
  logic [31:0]   w_r;
  logic          w_b;
  logic          w_qb;

  // Priority encode of the highest set divisor bit (0 when D==0).
  always_comb begin
    w_deg = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (D[i]) w_deg = 5'(i);
    end
  end

  // Unrolled long division; with a zero divisor the reduction is suppressed
  // so the shift chain leaves the dividend's low 32 bits in rem.
  always_comb begin
    w_nsh = r_nsh;
    w_quo = r_quo;
    w_rem = r_rem;
    w_r   = r_rem;
    w_b   = 1'b0;
    w_qb  = 1'b0;
    for (int i = 0; i < IT_PER_CYCLE; i++) begin
      w_b   = w_nsh[63];
      w_nsh = {w_nsh[62:0], 1'b0};
      w_r   = {w_rem[30:0], w_b};
      w_qb  = !r_div0 && w_r[r_deg];
      if (w_qb) w_r = w_r ^ r_d;
      w_rem = w_r;
      w_quo = {w_quo[62:0], w_qb};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= '0;
      r_nsh   <= '0;
      r_d     <= '0;
      r_deg   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_div0  <= 1'b0;
    end else if (!stall) begin
      if (start) begin
        r_state <= SW'(STEPS);
        r_nsh   <= N;
        r_d     <= D;
        r_deg   <= w_deg;
        r_quo   <= '0;
        r_rem   <= '0;
        r_div0  <= (D == 32'd0);
      end else if (r_state != '0) begin
        r_state <= r_state - 1'b1;
        r_nsh   <= w_nsh;
        r_quo   <= w_quo;
        r_rem   <= w_rem;
      end
    end
  end

  assign eoc         = (r_state == '0) && !start;
  assign quo         = r_quo;
  assign rem         = r_rem;
  assign div0        = r_div0;
  assign o_dbg_state = 7'(r_state);

endmodule
